// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and its iterative MDU.
package alu_ctrl_pkg;

    // Main-control op class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // ALUControl codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    // RV32M funct3
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// EX-stage decode/MDU bundle. master = pipeline side, slave = decoder/MDU side.
interface alu_ctrl_mdu_if #(parameter int XLEN = 32);
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            bit30;
    logic            bit25;
    logic            valid_in;
    logic            flush;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [3:0]      alu_ctrl;
    logic            is_mop;
    logic            mdu_stall;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    modport master (
        output alu_op, funct3, bit30, bit25, valid_in, flush, rs1_val, rs2_val,
        input  alu_ctrl, is_mop, mdu_stall, mdu_done, mdu_result
    );

    modport slave (
        input  alu_op, funct3, bit30, bit25, valid_in, flush, rs1_val, rs2_val,
        output alu_ctrl, is_mop, mdu_stall, mdu_done, mdu_result
    );
endinterface

// File: rtl/alu_ctrl_mdu_mdu_iter.sv
// Iterative radix-2 multiply/divide: shift-add multiply, restoring divide,
// both on operand magnitudes with a final sign-fixup cycle.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic              r_aneg, r_bneg;
    logic [XLEN-1:0]   r_b;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] r_acc;    // mul: {product hi, multiplier/product lo}; div: {rem, quotient}
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_a_signed, w_b_signed, w_aneg, w_bneg, w_div0, w_ovf;
    logic [XLEN-1:0]   w_amag, w_bmag;
    logic [XLEN:0]     w_add;
    logic [XLEN+1:0]   w_trial;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix;

    // Operand signedness and magnitudes at start; divide corner cases bypass CALC
    always_comb begin
        w_a_signed = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
        w_b_signed = i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1];
        w_aneg     = w_a_signed & i_a[XLEN-1];
        w_bneg     = w_b_signed & i_b[XLEN-1];
        w_amag     = w_aneg ? -i_a : i_a;
        w_bmag     = w_bneg ? -i_b : i_b;
        w_div0     = i_funct3[2] & (i_b == '0);
        w_ovf      = i_funct3[2] & ~i_funct3[0] & (i_a == MIN) & (i_b == '1);
    end

    // One iteration step and the sign-corrected final result
    always_comb begin
        w_add   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
        w_trial = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, r_b};
        w_prod  = (r_aneg ^ r_bneg) ? -r_acc : r_acc;
        w_quo   = (r_aneg ^ r_bneg) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem   = r_aneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        if (r_f3[2])
            w_fix = r_f3[1] ? w_rem : w_quo;
        else
            w_fix = (r_f3 == M_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // Sequencer: flush beats start and completion; done/result are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_aneg   <= 1'b0;
            r_bneg   <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (i_start) begin
                        r_f3   <= i_funct3;
                        r_aneg <= w_aneg;
                        r_bneg <= w_bneg;
                        if (w_div0) begin
                            r_result <= i_funct3[1] ? i_a : '1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_ovf) begin
                            r_result <= i_funct3[1] ? '0 : MIN;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, i_funct3[2] ? w_amag : w_bmag};
                            r_b     <= i_funct3[2] ? w_bmag : w_amag;
                            r_cnt   <= CW'(XLEN-1);
                            r_state <= S_CALC;
                        end
                    end
                    S_CALC: begin
                        if (r_f3[2])
                            r_acc <= w_trial[XLEN+1] ? {r_acc[2*XLEN-2:0], 1'b0}
                                                     : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                        else
                            r_acc <= r_acc[0] ? {w_add, r_acc[XLEN-1:1]}
                                              : {1'b0, r_acc[2*XLEN-1:1]};
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) r_state <= S_FIXUP;
                    end
                    S_FIXUP: begin
                        r_result <= w_fix;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_done   = r_done;
    assign o_result = r_result;
endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decoder with optional RV32M iterative MDU and stall.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int EN_M         = 1,
    parameter int LEGACY_CODES = 0
) (
    input  logic          clk,
    input  logic          reset,
    alu_ctrl_mdu_if.slave bus
);
    logic       w_is_mop;
    logic [3:0] w_ctrl;

    assign w_is_mop = (EN_M != 0) && (bus.alu_op == ALUOP_FUNCT) && bus.bit25;

    // Combinational ALUControl decode; M ops park the ALU on ADD
    always_comb begin
        w_ctrl = ALU_ADD;
        if (!w_is_mop) begin
            case (bus.alu_op)
                ALUOP_ADD:  w_ctrl = ALU_ADD;
                ALUOP_SUB:  w_ctrl = ALU_SUB;
                ALUOP_RSVD: w_ctrl = ALU_AND;
                default: begin
                    case (bus.funct3)
                        3'b000:  w_ctrl = bus.bit30 ? ALU_SUB : ALU_ADD;
                        3'b001:  w_ctrl = ALU_SLL;
                        3'b010:  w_ctrl = ALU_SLT;
                        3'b011:  w_ctrl = ALU_SLTU;
                        3'b100:  w_ctrl = ALU_XOR;
                        3'b101:  w_ctrl = bus.bit30 ? ALU_SRA : ALU_SRL;
                        3'b110:  w_ctrl = ALU_OR;
                        default: w_ctrl = ALU_AND;
                    endcase
                    // First-generation decoder only knew add/sub, or, and
                    if (LEGACY_CODES != 0 && bus.funct3 != 3'b000 &&
                        bus.funct3 != 3'b110 && bus.funct3 != 3'b111)
                        w_ctrl = ALU_BAD;
                end
            endcase
        end
    end

    assign bus.alu_ctrl = w_ctrl;
    assign bus.is_mop   = w_is_mop;

    generate
        if (EN_M != 0) begin : g_mdu
            logic w_done;
            logic w_start;
            assign w_start = bus.valid_in & w_is_mop & ~bus.flush;

            mdu_iter #(.XLEN(XLEN)) u_mdu (
                .clk      (clk),
                .reset    (reset),
                .i_start  (w_start),
                .i_flush  (bus.flush),
                .i_funct3 (bus.funct3),
                .i_a      (bus.rs1_val),
                .i_b      (bus.rs2_val),
                .o_done   (w_done),
                .o_result (bus.mdu_result)
            );

            // done is high exactly while the MDU sits in DONE, so it doubles as the state test
            assign bus.mdu_done  = w_done;
            assign bus.mdu_stall = bus.valid_in & w_is_mop & ~w_done;
        end else begin : g_no_mdu
            assign bus.mdu_done   = 1'b0;
            assign bus.mdu_stall  = 1'b0;
            assign bus.mdu_result = '0;
        end
    endgenerate
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode sweep, directed and random MDU ops vs. a
// 64-bit arithmetic reference, back-to-back, flush, async reset, EN_M=0.
module tb_alu_ctrl_mdu;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_ctrl_mdu_if #(.XLEN(32)) bus0();
    alu_ctrl_mdu_if #(.XLEN(32)) bus1();

    alu_ctrl_mdu #(.XLEN(32), .EN_M(1), .LEGACY_CODES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    alu_ctrl_mdu #(.XLEN(32), .EN_M(0), .LEGACY_CODES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    localparam logic [31:0] MIN = 32'h8000_0000;

    function automatic logic [3:0] ref_ctrl(input bit legacy, input bit enm,
            input logic [1:0] op, input logic [2:0] f3, input bit b30, input bit b25);
        if (enm && op == 2'b10 && b25) return 4'b0010;
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0000;
        if (legacy && !(f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7)) return 4'b1111;
        case (f3)
            3'd0: return b30 ? 4'b0110 : 4'b0010;
            3'd1: return 4'b0011;
            3'd2: return 4'b0100;
            3'd3: return 4'b0101;
            3'd4: return 4'b0111;
            3'd5: return b30 ? 4'b1001 : 4'b1000;
            3'd6: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    task automatic drive_idle();
        bus0.alu_op = 2'b00; bus0.funct3 = 3'd0; bus0.bit30 = 1'b0; bus0.bit25 = 1'b0;
        bus0.valid_in = 1'b0; bus0.flush = 1'b0; bus0.rs1_val = '0; bus0.rs2_val = '0;
        bus1.alu_op = 2'b00; bus1.funct3 = 3'd0; bus1.bit30 = 1'b0; bus1.bit25 = 1'b0;
        bus1.valid_in = 1'b0; bus1.flush = 1'b0; bus1.rs1_val = '0; bus1.rs2_val = '0;
    endtask

    // Issue one M op on bus0. in_done=1: issued during the previous op's DONE cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit in_done, input bit keep, input string tag);
        logic [31:0] exp_r;
        int          exp_l, lat;
        bit          stall_ok, stall_done;
        exp_r = ref_mdu(f3, a, b);
        exp_l = ref_lat(f3, a, b) + (in_done ? 1 : 0);
        @(negedge clk);
        bus0.alu_op = 2'b10; bus0.bit25 = 1'b1; bus0.bit30 = 1'b0; bus0.funct3 = f3;
        bus0.rs1_val = a; bus0.rs2_val = b; bus0.valid_in = 1'b1; bus0.flush = 1'b0;
        #1;
        stall_ok = (bus0.mdu_stall === (in_done ? 1'b0 : 1'b1));
        lat = 0; stall_done = 1'b0;
        for (int c = 1; c <= 80 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (bus0.mdu_done === 1'b1) begin
                lat = c;
                stall_done = (bus0.mdu_stall === 1'b0);
                n_chk++;
                if (bus0.mdu_result !== exp_r)
                    $display("FAIL %s result got=%h exp=%h", tag, bus0.mdu_result, exp_r);
                else n_pass++;
            end else if (bus0.mdu_stall !== 1'b1) stall_ok = 1'b0;
        end
        n_chk++;
        if (lat != exp_l) $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_l);
        else n_pass++;
        n_chk++;
        if (!(stall_ok && stall_done))
            $display("FAIL %s stall got=%0d/%0d exp=1/1", tag, stall_ok, stall_done);
        else n_pass++;
        if (!keep) begin
            @(negedge clk);
            bus0.valid_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({bus0.mdu_done, bus0.mdu_stall, bus0.mdu_result, bus0.alu_ctrl} !== {1'b0, 1'b0, 32'h0, 4'b0010})
            $display("FAIL reset got=%b/%b/%h/%b exp=0/0/0/0010", bus0.mdu_done, bus0.mdu_stall,
                     bus0.mdu_result, bus0.alu_ctrl);
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [3:0] e0, e1;
        for (int op = 0; op < 4; op++)
            for (int f = 0; f < 8; f++)
                for (int b30 = 0; b30 < 2; b30++)
                    for (int b25 = 0; b25 < 2; b25++) begin
                        bus0.alu_op = 2'(op); bus0.funct3 = 3'(f); bus0.bit30 = b30[0]; bus0.bit25 = b25[0];
                        bus1.alu_op = 2'(op); bus1.funct3 = 3'(f); bus1.bit30 = b30[0]; bus1.bit25 = b25[0];
                        #1;
                        e0 = ref_ctrl(1'b0, 1'b1, 2'(op), 3'(f), b30[0], b25[0]);
                        e1 = ref_ctrl(1'b1, 1'b0, 2'(op), 3'(f), b30[0], b25[0]);
                        n_chk++;
                        if ({bus0.alu_ctrl, bus0.is_mop} !== {e0, (op == 2 && b25 == 1)})
                            $display("FAIL decode op=%0d f3=%0d b30=%0d b25=%0d got=%b/%b exp=%b/%b",
                                     op, f, b30, b25, bus0.alu_ctrl, bus0.is_mop, e0, (op == 2 && b25 == 1));
                        else n_pass++;
                        n_chk++;
                        if ({bus1.alu_ctrl, bus1.is_mop} !== {e1, 1'b0})
                            $display("FAIL decode_legacy op=%0d f3=%0d b30=%0d b25=%0d got=%b/%b exp=%b/0",
                                     op, f, b30, b25, bus1.alu_ctrl, bus1.is_mop, e1);
                        else n_pass++;
                    end
        drive_idle();
    endtask

    task automatic test_directed();
        run_op(M_MUL,    32'd7,        32'hFFFF_FFFD, 1'b0, 1'b0, "mul");
        run_op(M_MULHU,  32'd7,        32'hFFFF_FFFD, 1'b0, 1'b0, "mulhu");
        run_op(M_MULH,   MIN,          MIN,           1'b0, 1'b0, "mulh_min");
        run_op(M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "mulhsu");
        run_op(M_DIV,    MIN,          32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_op(M_REM,    MIN,          32'hFFFF_FFFF, 1'b0, 1'b0, "rem_ovf");
        run_op(M_DIVU,   32'd5,        32'd0,         1'b0, 1'b0, "divu_0");
        run_op(M_REMU,   32'd5,        32'd0,         1'b0, 1'b0, "remu_0");
        run_op(M_REM,    -32'sd7,      32'd2,         1'b0, 1'b0, "rem_neg");
        run_op(M_DIV,    -32'sd7,      32'd2,         1'b0, 1'b0, "div_neg");
    endtask

    task automatic test_back_to_back();
        run_op(M_MUL,  32'd1234, 32'd5678,      1'b0, 1'b1, "b2b_0");
        run_op(M_DIVU, 32'd1000, 32'd33,        1'b1, 1'b1, "b2b_1");
        run_op(M_DIVU, 32'd9,    32'd0,         1'b1, 1'b1, "b2b_2");
        run_op(M_REM,  32'd77,   32'hFFFF_FFF6, 1'b1, 1'b0, "b2b_3");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = '0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(0, 20)) - 32'd10; end
                default: ;
            endcase
            run_op(f3, a, b, 1'b0, 1'b0, $sformatf("rand%0d_f%0d", i, f3));
        end
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk);
        bus0.alu_op = 2'b10; bus0.bit25 = 1'b1; bus0.funct3 = M_DIV;
        bus0.rs1_val = 32'd1000; bus0.rs2_val = 32'd3; bus0.valid_in = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (bus0.mdu_done === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        bus0.flush = 1'b1;
        @(posedge clk); #1;
        if (bus0.mdu_done === 1'b1) seen = 1'b1;
        n_chk++;
        if (seen) $display("FAIL flush done got=1 exp=0");
        else n_pass++;
        run_op(M_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, "after_flush");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus0.alu_op = 2'b10; bus0.bit25 = 1'b1; bus0.funct3 = M_MUL;
        bus0.rs1_val = 32'h1234; bus0.rs2_val = 32'h5678; bus0.valid_in = 1'b1;
        repeat (12) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({bus0.mdu_done, bus0.mdu_result} !== {1'b0, 32'h0})
            $display("FAIL async_reset got=%b/%h exp=0/00000000", bus0.mdu_done, bus0.mdu_result);
        else n_pass++;
        @(negedge clk);
        bus0.valid_in = 1'b0;
        reset = 1'b0;
        run_op(M_MUL, 32'd3, 32'd4, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_no_m();
        bit bad;
        @(negedge clk);
        bus1.alu_op = 2'b10; bus1.bit25 = 1'b1; bus1.funct3 = M_DIV;
        bus1.rs1_val = 32'd5; bus1.rs2_val = 32'd0; bus1.valid_in = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if ({bus1.is_mop, bus1.mdu_stall, bus1.mdu_done, bus1.mdu_result} !== 35'h0) bad = 1'b1;
        end
        n_chk++;
        if (bad) $display("FAIL no_m got=%b/%b/%b/%h exp=0/0/0/0", bus1.is_mop, bus1.mdu_stall,
                          bus1.mdu_done, bus1.mdu_result);
        else n_pass++;
        bus1.valid_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_decode();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_async_reset();
        test_no_m();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised successor to the pipeline's ALU control decoder, for the EX stage. It decodes the full RV32I R/I-type funct3 space to 4-bit ALUControl codes. It also decodes the RV32M extension (funct7[0]=1) and sequences an iterative multiply/divide unit. While that unit runs, it stalls the pipeline through a stall/done handshake.

Parameters:
XLEN, 32, operand/result width (power of 2, >=8)
EN_M, 1, 0 = M-extension decode and MDU disabled (M encodings decode as ordinary R-type)
LEGACY_CODES, 0, 1 = funct3 outside {000,110,111} with alu_op=10 yields 4'b1111, matching the first-generation decoder

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
alu_op  in  2  main-control op class: 00 add, 01 sub, 10 funct-decoded, 11 reserved
funct3  in  3  instruction funct3
bit30  in  1  instruction bit 30 (sub/sra select)
bit25  in  1  instruction bit 25 (M-extension select)
valid_in  in  1  EX-stage instruction valid
flush  in  1  pipeline flush, kills any in-flight MDU op
rs1_val  in  XLEN  operand A
rs2_val  in  XLEN  operand B
alu_ctrl  out  4  ALU operation code
is_mop  out  1  current instruction is an M op (result must come from mdu_result)
mdu_stall  out  1  hold IF/ID/EX, bubble MEM
mdu_done  out  1  one-cycle pulse: mdu_result valid
mdu_result  out  XLEN  MDU result

Behaviour:
- alu_ctrl is combinational:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0000.
  - alu_op 10, by funct3: 000 -> 0010, or 0110 if bit30; 001 -> 0011 (sll); 010 -> 0100 (slt); 011 -> 0101 (sltu); 100 -> 0111 (xor); 101 -> 1000 (srl), or 1001 if bit30 (sra); 110 -> 0001 (or); 111 -> 0000 (and).
  - LEGACY_CODES=1 overrides the extra funct3 values with 1111.
- is_mop = EN_M & alu_op==10 & bit25. When is_mop=1, alu_ctrl = 0010 (don't-care for the datapath).
- MDU funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states:
  - IDLE: start = valid_in & is_mop & ~flush. On start, capture operands and funct3.
    - Divisor 0 -> DONE with quotient all-ones, remainder = dividend.
    - Signed DIV/REM of MIN by -1 -> DONE with quotient MIN, remainder 0.
    - Otherwise -> CALC.
  - CALC: operate on magnitudes of the operands, radix-2, one bit per cycle.
    - Counter loads XLEN-1 on entry and decrements; at 0 -> FIXUP.
    - Multiply: 2*XLEN product register. Divide: restoring division.
  - FIXUP: apply sign correction to the product, quotient or remainder. Remainder takes the dividend's sign. Select the high or low product half. -> DONE.
  - DONE: mdu_done=1, mdu_result valid for this one cycle -> IDLE.
- Latency start->done: XLEN+2 cycles (34 at XLEN=32). Special divide cases: 1 cycle.
- mdu_stall = valid_in & is_mop & (state != DONE), combinational. It is high in the start cycle and low in DONE, so the instruction retires with the result in DONE.
- valid_in/operand changes while not IDLE are ignored. Operands are only sampled at start.
- flush in any state: next state IDLE, no mdu_done, registers keep stale data. flush has priority over start and over completion.
- Async reset in any state: IDLE; mdu_done=0, mdu_result=0, counter=0. Takes effect immediately, including mid-CALC.
- Back-to-back M ops: IDLE is entered the cycle after DONE, so a new start is accepted on that cycle. Throughput is 1 op per XLEN+3 cycles.
- EN_M=0: is_mop=0, mdu_stall=0, mdu_done=0, mdu_result=0. The MDU logic is not generated.

Decomposition:
- Package alu_ctrl_pkg holds:
  - alu_op encodings (ALUOP_ADD/SUB/FUNCT/RSVD);
  - 4-bit ALUControl constants (ALU_AND 0000, ALU_OR 0001, ALU_ADD 0010, ALU_SLL 0011, ALU_SLT 0100, ALU_SLTU 0101, ALU_SUB 0110, ALU_XOR 0111, ALU_SRL 1000, ALU_SRA 1001, ALU_BAD 1111);
  - M funct3 constants;
  - the MDU state enum.
- Sub-module mdu_iter contains the FSM, counter, shift registers and sign fixup; it is parametrised by XLEN. The top level holds the combinational decoder, instantiates mdu_iter under EN_M, and forms mdu_stall.

Test Plan:
- Decode sweep: all alu_op/funct3/bit30 values with bit25=0 -> alu_ctrl matches the table above. Repeat with LEGACY_CODES=1: funct3=001 -> 1111, funct3=000 & bit30 -> 0110.
- MUL 7 * 0xFFFFFFFD -> mdu_stall high for 34 cycles; mdu_done pulses in cycle 34 after start with result 0xFFFFFFEB. MULHU of the same operands -> 0x00000006.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done 1 cycle after start; REM of the same -> 0. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. REM -7/2 -> 0xFFFFFFFF.
- Flush at CALC cycle 10 of a DIV -> IDLE next cycle, no mdu_done. A DIVU 100/7 started the next cycle -> 14 after 34 cycles.
- Async reset asserted mid-CALC between clock edges -> mdu_done=0 and mdu_result=0 immediately. After release, MUL 3*4 -> 12 with full latency.
